reference_model: RTL and testbench
==================================

Name: reference_model

Overview:
- Cycle-accurate decode model of the 8237-style DMA controller's program-mode register interface, used alongside the DMA RTL.
- Watches the CPU-side bus (CS_N, IOR_N, IOW_N, A3..A0) and the DUT's programCondition.
- Produces one-cycle strobes for every register access, plus the byte-pointer flip-flop state.
- Verification properties compare DUT register updates against these strobes.

Parameters:
- CHANNELS, 4, number of DMA channels (channel select width is 2).

Ports:
- CLK  input  1  system clock, all state on rising edge
- RESET  input  1  synchronous, active-high reset
- CS_N  input  1  chip select, active low
- IOR_N  input  1  I/O read strobe, active low
- IOW_N  input  1  I/O write strobe, active low
- A3, A2, A1, A0  input  1 each  register address
- programCondition  input  1  DUT is idle/program mode (HLDA low); enables decode
- loadCommandReg  output  1  write to 1000
- readStatusReg  output  1  read of 1000
- loadIoDataBufferFromStatus  output  1  same as readStatusReg (ioDataBuffer takes statusReg next cycle)
- loadRequestReg  output  1  write to 1001
- readTemporaryReg  output  1  read of 1101
- loadSingleMaskBit  output  1  write to 1010
- loadModeReg  output  1  write to 1011
- clearInternalFF  output  1  write to 1100
- masterClear  output  1  write to 1101
- clearMaskReg  output  1  write to 1110
- loadAllMaskBits  output  1  write to 1111
- loadBaseAddressReg  output  1  write with A3=0, A0=0 (base and current address)
- loadBaseWordCountReg  output  1  write with A3=0, A0=1 (base and current count)
- readCurrentAddressReg  output  1  read with A3=0, A0=0
- readCurrentWordCountReg  output  1  read with A3=0, A0=1
- channelSelect  output  2  {A2,A1}, valid during A3=0 strobes, else 0
- internalFF  output  1  byte pointer: 0 = low byte next, 1 = high byte next

Behaviour:
- Registered samples: prevIOR_N and prevIOW_N, both reset to 1.
- Write-start condition, valid = programCondition & !CS_N & !IOW_N & prevIOW_N & IOR_N.
- Read-start condition, valid = programCondition & !CS_N & !IOR_N & prevIOR_N & IOW_N.
- All strobes are combinational from the current cycle and last exactly one cycle per bus access, however long IOR_N/IOW_N stays low.
- IOR_N and IOW_N low together: no strobes, and the FF is unchanged.
- CS_N high or programCondition low: no strobes.
- Exactly one strobe fires per valid access. Reads of 1001, 1010, 1011, 1100, 1110 and 1111 produce no strobe.
- internalFF:
  - Resets to 0.
  - Cleared at the next edge by clearInternalFF or masterClear.
  - Otherwise toggles at the next edge on any of the four A3=0 strobes (read or write).
  - Output is the current register value, so the access that toggles it sees the pre-toggle value.
- RESET high:
  - All outputs read 0 in the same cycle; strobes are gated by !RESET.
  - internalFF and channelSelect are 0.
  - prevIOR_N and prevIOW_N are forced to 1 at the edge.
- Reset in the middle of a bus cycle: an IOR_N/IOW_N held low across reset deassertion generates no strobe until it returns high and falls again. Because prev samples are forced to 1, design this explicitly: also hold prev low while the strobe is low.
- The model holds no data registers; it decodes only.

Decomposition:
- Shared package dma_pkg: register address localparams (CMD_STATUS=4'b1000, REQUEST=4'b1001, SINGLE_MASK=4'b1010, MODE=4'b1011, CLEAR_FF=4'b1100, MASTER_CLEAR=4'b1101, CLEAR_MASK=4'b1110, ALL_MASK=4'b1111), plus the 6-bit one-hot timing-state constants SI/SO/S1/S2/S3/S4 reused by checkers.
- One natural sub-module, edge_start_detect: registered prev sample plus start pulse, instantiated for IOR_N and IOW_N.

Test Plan:
- Command write: CS_N=0, programCondition=1, A=1000, IOW_N low for 3 cycles -> loadCommandReg=1 in the first cycle only; all other outputs 0.
- Status read: A=1000, IOR_N low -> readStatusReg=1 and loadIoDataBufferFromStatus=1 for one cycle; internalFF unchanged.
- Address byte pair: A=0100, two separate IOW_N pulses -> loadBaseAddressReg=1 each time with channelSelect=2'b10. internalFF reads 0 during the first pulse, 1 during the second, 0 afterwards.
- FF clear: after one A=0011 write (internalFF=1), write A=1100 -> clearInternalFF pulse, internalFF=0 next cycle. Repeat using A=1101 -> masterClear pulse, FF cleared.
- Gating: programCondition=0 or CS_N=1 with IOW_N pulses at every address -> no strobes, internalFF constant. IOR_N and IOW_N low together -> no strobes.
- Reset: assert RESET mid-access with IOW_N held low, release RESET -> no strobe until IOW_N rises and falls again. All outputs 0 while RESET=1.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: register addresses and timing-state encodings shared by the DMA model and checkers
package dma_pkg;
   localparam logic [3:0] CMD_STATUS   = 4'b1000;
   localparam logic [3:0] REQUEST      = 4'b1001;
   localparam logic [3:0] SINGLE_MASK  = 4'b1010;
   localparam logic [3:0] MODE         = 4'b1011;
   localparam logic [3:0] CLEAR_FF     = 4'b1100;
   localparam logic [3:0] MASTER_CLEAR = 4'b1101;
   localparam logic [3:0] CLEAR_MASK   = 4'b1110;
   localparam logic [3:0] ALL_MASK     = 4'b1111;
   localparam logic [5:0] SI = 6'b000001;
   localparam logic [5:0] SO = 6'b000010;
   localparam logic [5:0] S1 = 6'b000100;
   localparam logic [5:0] S2 = 6'b001000;
   localparam logic [5:0] S3 = 6'b010000;
   localparam logic [5:0] S4 = 6'b100000;
endpackage

// File: rtl/edge_start_detect.sv
// edge_start_detect: one-cycle start pulse on the falling edge of an active-low bus strobe
module edge_start_detect (
   input  logic clk,
   input  logic rst,
   input  logic strobe_n,
   output logic start
);
   logic prev_q, prev_d, block_q, block_d;
   always_comb begin
      prev_d  = strobe_n;
      block_d = block_q & ~strobe_n;
   end
   // a strobe already low at reset stays blocked until it returns high
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q  <= 1'b1;
         block_q <= ~strobe_n;
      end else begin
         prev_q  <= prev_d;
         block_q <= block_d;
      end
   end
   assign start = ~strobe_n & prev_q & ~block_q;
endmodule

// File: rtl/reference_model.sv
// reference_model: decodes program-mode CPU accesses of an 8237-style DMA into one-cycle strobes
module reference_model
   import dma_pkg::*;
#(
   parameter int CHANNELS = 4
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic                        CS_N,
   input  logic                        IOR_N,
   input  logic                        IOW_N,
   input  logic                        A3,
   input  logic                        A2,
   input  logic                        A1,
   input  logic                        A0,
   input  logic                        programCondition,
   output logic                        loadCommandReg,
   output logic                        readStatusReg,
   output logic                        loadIoDataBufferFromStatus,
   output logic                        loadRequestReg,
   output logic                        readTemporaryReg,
   output logic                        loadSingleMaskBit,
   output logic                        loadModeReg,
   output logic                        clearInternalFF,
   output logic                        masterClear,
   output logic                        clearMaskReg,
   output logic                        loadAllMaskBits,
   output logic                        loadBaseAddressReg,
   output logic                        loadBaseWordCountReg,
   output logic                        readCurrentAddressReg,
   output logic                        readCurrentWordCountReg,
   output logic [$clog2(CHANNELS)-1:0] channelSelect,
   output logic                        internalFF
);
   logic       rd_start, wr_start, wr, rd, chan_acc, ff_q, ff_d;
   logic [3:0] addr;
   edge_start_detect u_rd (.clk(CLK), .rst(RESET), .strobe_n(IOR_N), .start(rd_start));
   edge_start_detect u_wr (.clk(CLK), .rst(RESET), .strobe_n(IOW_N), .start(wr_start));
   always_comb begin
      addr     = {A3, A2, A1, A0};
      wr       = ~RESET & programCondition & ~CS_N & wr_start & IOR_N;
      rd       = ~RESET & programCondition & ~CS_N & rd_start & IOW_N;
      chan_acc = (wr | rd) & ~A3;
      loadCommandReg             = wr & (addr == CMD_STATUS);
      readStatusReg              = rd & (addr == CMD_STATUS);
      loadIoDataBufferFromStatus = readStatusReg;
      loadRequestReg             = wr & (addr == REQUEST);
      readTemporaryReg           = rd & (addr == MASTER_CLEAR);
      loadSingleMaskBit          = wr & (addr == SINGLE_MASK);
      loadModeReg                = wr & (addr == MODE);
      clearInternalFF            = wr & (addr == CLEAR_FF);
      masterClear                = wr & (addr == MASTER_CLEAR);
      clearMaskReg               = wr & (addr == CLEAR_MASK);
      loadAllMaskBits            = wr & (addr == ALL_MASK);
      loadBaseAddressReg         = wr & ~A3 & ~A0;
      loadBaseWordCountReg       = wr & ~A3 & A0;
      readCurrentAddressReg      = rd & ~A3 & ~A0;
      readCurrentWordCountReg    = rd & ~A3 & A0;
      channelSelect              = chan_acc ? {A2, A1} : '0;
      ff_d = (clearInternalFF | masterClear) ? 1'b0 : chan_acc ? ~ff_q : ff_q;
      internalFF = ff_q & ~RESET;
   end
   always_ff @(posedge CLK) begin
      if (RESET) ff_q <= 1'b0;
      else       ff_q <= ff_d;
   end
endmodule

// File: tb/tb_reference_model.sv
// tb_reference_model: directed table, corner sequences and randomized run against a behavioural model
module tb_reference_model;
   logic clk = 1'b0, rst, cs_n, ior_n, iow_n, pc;
   logic [3:0] a;
   logic cmd, rstat, iob, req, tmp, smk, mdr, cff, mcl, cmk, amk, ba, bwc, rca, rcw, ff;
   logic [1:0] ch;
   int tests = 0, fails = 0;

   localparam int B_CMD = 0, B_RST = 1, B_IOB = 2, B_REQ = 3, B_TMP = 4, B_SMK = 5, B_MOD = 6,
                  B_CFF = 7, B_MCL = 8, B_CMK = 9, B_AMK = 10, B_BA = 11, B_BWC = 12, B_RCA = 13, B_RCW = 14;

   always #5 clk = ~clk;

   reference_model #(.CHANNELS(4)) dut (
      .CLK(clk), .RESET(rst), .CS_N(cs_n), .IOR_N(ior_n), .IOW_N(iow_n),
      .A3(a[3]), .A2(a[2]), .A1(a[1]), .A0(a[0]), .programCondition(pc),
      .loadCommandReg(cmd), .readStatusReg(rstat), .loadIoDataBufferFromStatus(iob),
      .loadRequestReg(req), .readTemporaryReg(tmp), .loadSingleMaskBit(smk), .loadModeReg(mdr),
      .clearInternalFF(cff), .masterClear(mcl), .clearMaskReg(cmk), .loadAllMaskBits(amk),
      .loadBaseAddressReg(ba), .loadBaseWordCountReg(bwc), .readCurrentAddressReg(rca),
      .readCurrentWordCountReg(rcw), .channelSelect(ch), .internalFF(ff)
   );

   wire [14:0] dut_str = {rcw, rca, bwc, ba, amk, cmk, mcl, cff, mdr, smk, tmp, req, iob, rstat, cmd};

   // model state: byte pointer, and whether each strobe's current low phase was already seen
   logic m_ff = 1'b0, m_wr_busy = 1'b0, m_rd_busy = 1'b0;
   logic [14:0] m_str;
   logic [1:0]  m_ch;
   logic        m_ffo;

   function automatic int wr_target(logic [3:0] ad);
      if (ad < 4'd8) return ad[0] ? B_BWC : B_BA;
      case (ad)
         4'd8: return B_CMD;  4'd9: return B_REQ;  4'd10: return B_SMK; 4'd11: return B_MOD;
         4'd12: return B_CFF; 4'd13: return B_MCL; 4'd14: return B_CMK; default: return B_AMK;
      endcase
   endfunction

   function automatic int rd_target(logic [3:0] ad);
      if (ad < 4'd8) return ad[0] ? B_RCW : B_RCA;
      if (ad == 4'd8) return B_RST;
      if (ad == 4'd13) return B_TMP;
      return -1;
   endfunction

   task automatic model_step();
      bit wr_go, rd_go;
      int t;
      wr_go = !rst && pc && !cs_n && !iow_n && ior_n && !m_wr_busy;
      rd_go = !rst && pc && !cs_n && !ior_n && iow_n && !m_rd_busy;
      m_str = '0;
      if (wr_go) m_str[wr_target(a)] = 1'b1;
      if (rd_go) begin
         t = rd_target(a);
         if (t >= 0) m_str[t] = 1'b1;
         if (t == B_RST) m_str[B_IOB] = 1'b1;
      end
      m_ch  = ((wr_go || rd_go) && a < 4'd8) ? a[2:1] : 2'b00;
      m_ffo = rst ? 1'b0 : m_ff;
      if (rst || (wr_go && (a == 4'd12 || a == 4'd13))) m_ff = 1'b0;
      else if ((wr_go || rd_go) && a < 4'd8) m_ff = ~m_ff;
      m_wr_busy = !iow_n;
      m_rd_busy = !ior_n;
   endtask

   task automatic drive(input logic r, input logic c, input logic rn, input logic wn, input logic p, input logic [3:0] ad);
      @(negedge clk);
      rst = r; cs_n = c; ior_n = rn; iow_n = wn; pc = p; a = ad;
      #1;
      model_step();
   endtask

   task automatic check(input string name, input logic [14:0] es, input logic [1:0] ec, input logic ef);
      tests++;
      if (dut_str !== es || ch !== ec || ff !== ef) begin
         fails++;
         $display("FAIL %s: strobes=%h ch=%0d ff=%0b, expected strobes=%h ch=%0d ff=%0b",
                  name, dut_str, ch, ff, es, ec, ef);
      end
   endtask

   typedef struct {
      logic r, c, rn, wn, p;
      logic [3:0] ad;
      logic [14:0] es;
      logic [1:0] ec;
      logic ef;
      string name;
   } vec_t;

   function automatic vec_t v(logic r, logic c, logic rn, logic wn, logic p, logic [3:0] ad,
                              int bit_n, logic [1:0] ec, logic ef, string name);
      vec_t x;
      x.r = r; x.c = c; x.rn = rn; x.wn = wn; x.p = p; x.ad = ad;
      x.es = '0;
      if (bit_n >= 0) x.es[bit_n] = 1'b1;
      if (bit_n == B_RST) x.es[B_IOB] = 1'b1;
      x.ec = ec; x.ef = ef; x.name = name;
      return x;
   endfunction

   vec_t tbl[$];

   initial begin
      tbl.push_back(v(1,1,1,1,1,4'h0,-1,0,0,"reset"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,0,"idle"));
      tbl.push_back(v(0,0,1,0,1,4'h8,B_CMD,0,0,"cmd_wr_first"));
      tbl.push_back(v(0,0,1,0,1,4'h8,-1,0,0,"cmd_wr_held1"));
      tbl.push_back(v(0,0,1,0,1,4'h8,-1,0,0,"cmd_wr_held2"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,0,"idle"));
      tbl.push_back(v(0,0,0,1,1,4'h8,B_RST,0,0,"status_rd"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,0,"status_ff_kept"));
      tbl.push_back(v(0,0,1,0,1,4'h4,B_BA,2,0,"addr_lo"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,1,"ff_after_lo"));
      tbl.push_back(v(0,0,1,0,1,4'h4,B_BA,2,1,"addr_hi"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,0,"ff_after_hi"));
      tbl.push_back(v(0,0,1,0,1,4'h3,B_BWC,1,0,"count_wr"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,1,"ff_set"));
      tbl.push_back(v(0,0,1,0,1,4'hC,B_CFF,0,1,"clear_ff_wr"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,0,"ff_cleared"));
      tbl.push_back(v(0,0,1,0,1,4'h3,B_BWC,1,0,"count_wr2"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,1,"ff_set2"));
      tbl.push_back(v(0,0,1,0,1,4'hD,B_MCL,0,1,"master_clear"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,0,"ff_mc_cleared"));
      tbl.push_back(v(0,0,0,1,1,4'hD,B_TMP,0,0,"temp_rd"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,0,"idle"));
      tbl.push_back(v(0,0,0,1,1,4'h6,B_RCA,3,0,"cur_addr_rd"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,1,"idle"));
      tbl.push_back(v(0,0,0,1,1,4'h1,B_RCW,0,1,"cur_count_rd"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,0,"idle"));
      tbl.push_back(v(0,0,1,0,0,4'h0,-1,0,0,"pc_low"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,0,"idle"));
      tbl.push_back(v(0,1,1,0,1,4'h0,-1,0,0,"cs_high"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,0,"idle"));
      tbl.push_back(v(0,0,0,0,1,4'h0,-1,0,0,"both_low"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,0,"idle"));
      tbl.push_back(v(0,0,0,1,1,4'h9,-1,0,0,"rd_request_none"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,0,"idle"));
      tbl.push_back(v(0,0,1,0,1,4'hA,B_SMK,0,0,"smask_wr"));
      tbl.push_back(v(1,0,1,0,1,4'hA,-1,0,0,"reset_mid_access"));
      tbl.push_back(v(0,0,1,0,1,4'hA,-1,0,0,"held_after_reset1"));
      tbl.push_back(v(0,0,1,0,1,4'hA,-1,0,0,"held_after_reset2"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,0,"idle"));
      tbl.push_back(v(0,0,1,0,1,4'hA,B_SMK,0,0,"smask_wr_again"));
      tbl.push_back(v(0,1,1,1,1,4'h0,-1,0,0,"idle"));

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].c, tbl[i].rn, tbl[i].wn, tbl[i].p, tbl[i].ad);
         check(tbl[i].name, tbl[i].es, tbl[i].ec, tbl[i].ef);
      end

      // reset while the byte pointer is set and a write would start
      drive(0,0,1,0,1,4'h0); check("seq_ba_lo", 15'(1 << B_BA), 0, 0);
      drive(0,1,1,1,1,4'h0); check("seq_ff_set", '0, 0, 1);
      drive(1,0,1,0,1,4'h0); check("seq_reset_outputs", '0, 0, 0);
      drive(0,1,1,1,1,4'h0); check("seq_ff_after_reset", '0, 0, 0);
      drive(0,0,1,0,1,4'h0); check("seq_ba_after_reset", 15'(1 << B_BA), 0, 0);
      drive(0,1,1,1,1,4'h0); check("seq_ff_set2", '0, 0, 1);
      // gating sweep at every address keeps the pointer untouched
      for (int ad = 0; ad < 16; ad++) begin
         drive(0,0,1,0,0,4'(ad)); check("gate_pc", '0, 0, 1);
         drive(0,1,1,1,1,4'(ad));
         drive(0,1,1,0,1,4'(ad)); check("gate_cs", '0, 0, 1);
         drive(0,1,1,1,1,4'(ad));
         drive(0,0,0,0,1,4'(ad)); check("gate_both", '0, 0, 1);
         drive(0,1,1,1,1,4'(ad));
      end
      // overlapping strobes: write never starts while read was still low
      drive(0,0,0,1,1,4'h0); check("ovl_read", 15'(1 << B_RCA), 0, 1);
      drive(0,0,0,0,1,4'h0); check("ovl_both", '0, 0, 0);
      drive(0,0,1,0,1,4'h0); check("ovl_write_held", '0, 0, 0);
      drive(0,1,1,1,1,4'h0); check("ovl_idle", '0, 0, 0);

      // randomized traffic against the behavioural model
      drive(1,1,1,1,1,4'h0);
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(63) == 0, $urandom_range(5) == 0, $urandom_range(2) == 0,
               $urandom_range(2) == 0, $urandom_range(7) != 0, 4'($urandom));
         check("random", m_str, m_ch, m_ffo);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
